seqdet_prog: RTL and testbench
==============================

# seqdet_prog

Programmable, parametrised symbol-sequence detector. It is the successor to the fixed 8-symbol, 3-bit sequence detector. The pattern, its length and the match mode are loaded at run time, and a mismatch restarts detection correctly instead of stalling. It sits on a qualified symbol stream (`in_valid`/`in_sym`) and reports registered match pulses, a saturating match count and a one-shot completion flag to control logic.

## Interface
Parameters:
- `SYM_W`, 3: symbol width in bits.
- `MAX_LEN`, 8: maximum pattern length in symbols; must be ≥ 2.
- `CNT_W`, 8: width of the match counter.
- `LEN_W`: derived as $clog2(MAX_LEN+1); not overridable.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: symbol beat strobe.
- `in_sym` in SYM_W: symbol, sampled when `in_valid`=1.
- `cfg_we` in 1: pattern-slot write strobe.
- `cfg_idx` in $clog2(MAX_LEN): slot index; 0 is the first (oldest) symbol of the pattern.
- `cfg_sym` in SYM_W: value written to the slot.
- `cfg_len_we` in 1: length write strobe.
- `cfg_len` in LEN_W: pattern length.
- `cfg_mode` in 2: 0 = OVERLAP, 1 = NONOVERLAP, 2 = ONESHOT, 3 = reserved (behaves as OVERLAP); sampled on `arm`.
- `arm` in 1: start detection.
- `disarm` in 1: stop detection.
- `match` out 1: registered 1-cycle pulse per detected match.
- `match_count` out CNT_W: count of matches since the last arm; saturating.
- `busy` out 1: high while in ARMED.
- `done` out 1: high while in DONE.

## Operation
- FSM states: IDLE, ARMED, DONE. Reset state is IDLE.
- IDLE → ARMED on `arm`. On that transition: latch `cfg_mode`, clear the history fill counter, clear `match_count`.
- ARMED → DONE on a match when the latched mode is ONESHOT.
- DONE → ARMED on `arm`, which re-latches the mode and clears fill and count.
- Any state → IDLE on `disarm`. If `disarm` and `arm` are asserted together, `disarm` wins.
- Configuration:
  - `cfg_we` and `cfg_len_we` take effect only in IDLE; in ARMED or DONE they are ignored.
  - A `cfg_len` of 0 is ignored. A `cfg_len` greater than MAX_LEN is clamped to MAX_LEN.
  - `cfg_idx` ≥ MAX_LEN is ignored.
- Reset values of configuration: pattern slots all 0; length = MAX_LEN.
- History:
  - MAX_LEN-entry shift register; `hist[0]` is the newest symbol.
  - On every `in_valid` beat in ARMED: shift in `in_sym`, and `fill` increments, saturating at MAX_LEN.
  - `in_valid` in IDLE or DONE is ignored; history and fill are not updated.
- Match condition, evaluated on the post-shift history of an accepted beat:
  - `fill` ≥ `len`, and
  - `hist[i] == pat[len-1-i]` for every i < `len`.
- Effects of a match:
  - OVERLAP: history and fill are kept, so overlapping occurrences all count.
  - NONOVERLAP: fill is cleared to 0, so the next match needs `len` fresh beats.
  - ONESHOT: transition to DONE.
- Counter: `match_count` increments on each match and saturates at 2^CNT_W−1; `match` still pulses at saturation.
- A match beat in the same cycle as `disarm` produces no `match` pulse and no count increment.

## Timing
- All outputs are registered. Reset values: `match`=0, `match_count`=0, `busy`=0, `done`=0.
- Latency: `match` is high in the cycle after the rising edge that accepts the completing beat. `match_count` updates at the same edge.
- `busy` rises the cycle after `arm` and falls the cycle after `disarm` or the ONESHOT match.
- `done` rises together with the ONESHOT `match` pulse.
- A beat accepted on the same edge as `arm` is not sampled; the first sampled beat is the one after ARMED is entered.
- Back-to-back `in_valid` at full rate is supported. In OVERLAP with `len`=1, `match` may stay high on consecutive cycles.
- Asserting `reset_n` mid-sequence clears the state, history, fill, outputs and configuration immediately (asynchronously). Deassertion is synchronous to `clk` via the standard reset synchroniser upstream.

## Structure
- Shared package `seqdet_pkg`:
  - state enum `seqdet_state_t` (IDLE, ARMED, DONE);
  - mode enum `seqdet_mode_t` (OVERLAP, NONOVERLAP, ONESHOT);
  - mode encoding constants.
- Sub-module `seqdet_history`:
  - parametrised shift register plus fill counter;
  - inputs: `shift`, `clear`, `sym`;
  - outputs: the flattened history and `fill`.
- The comparator, FSM and counter stay in `seqdet_prog`.

## Test plan
1. Defaults SYM_W=3, MAX_LEN=8. Load pattern 1,5,6,0,6,6,3,5, `len`=8, OVERLAP, `arm`. Stream 7,1,5,6,0,6,6,3,5 → exactly one `match` pulse, one cycle after the beat 5; `match_count`=1.
2. Pattern 6,6, `len`=2. Stream 6,6,6,6: OVERLAP → 3 matches; NONOVERLAP → 2 matches.
3. Mismatch restart: pattern 1,1,2, `len`=3. Stream 1,1,1,2 → `match` on the final beat (the prior 1,1,1 must not block detection).
4. ONESHOT with pattern 4 (`len`=1). Stream 4,4 → one `match` pulse, `done`=1, `busy`=0, count stays 1. Then `arm` → `done`=0, `busy`=1, count 0.
5. `cfg_we` while ARMED, `cfg_len` = 0 or 12: pattern and length unchanged; `cfg_len`=12 written in IDLE reads back as 8 effective (full-length match required).
6. Overflow and stop: CNT_W=2 with 5 matches → count saturates at 3 while `match` still pulses. `disarm` on a completing beat → no pulse. `reset_n` low mid-pattern → all outputs 0 and length returns to 8.

Source files
------------

// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared state/mode types and encodings for the programmable sequence detector
package seqdet_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ARMED = S_ARMED,
    ST_DONE  = S_DONE
  } seqdet_state_t;

  localparam logic [1:0] MODE_ENC_OVERLAP    = 2'd0;
  localparam logic [1:0] MODE_ENC_NONOVERLAP = 2'd1;
  localparam logic [1:0] MODE_ENC_ONESHOT    = 2'd2;

  typedef enum logic [1:0] {
    MODE_OVERLAP    = MODE_ENC_OVERLAP,
    MODE_NONOVERLAP = MODE_ENC_NONOVERLAP,
    MODE_ONESHOT    = MODE_ENC_ONESHOT
  } seqdet_mode_t;

  // The reserved encoding folds onto OVERLAP.
  function automatic seqdet_mode_t decode_mode(input logic [1:0] enc);
    case (enc)
      MODE_ENC_NONOVERLAP: return MODE_NONOVERLAP;
      MODE_ENC_ONESHOT:    return MODE_ONESHOT;
      default:             return MODE_OVERLAP;
    endcase
  endfunction

endpackage

// File: rtl/seqdet_history.sv
// rtl/seqdet_history.sv - symbol history shift register with saturating fill counter
module seqdet_history
  import seqdet_pkg::*;
#(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     shift,
  input  logic                     clear,
  input  logic [SYM_W-1:0]         sym,
  output logic [MAX_LEN*SYM_W-1:0] hist,
  output logic [LEN_W-1:0]         fill
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

  // Slot 0 (LSBs) holds the newest symbol; clear resets only the fill count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift) hist <= {hist[(MAX_LEN-1)*SYM_W-1:0], sym};
      if (clear) fill <= '0;
      else if (shift && fill != FULL) fill <= fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seqdet_prog.sv
// rtl/seqdet_prog.sv - programmable symbol-sequence detector: config, comparator, FSM and match counter
module seqdet_prog
  import seqdet_pkg::*;
#(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [SYM_W-1:0]           in_sym,
  input  logic                       cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0] cfg_idx,
  input  logic [SYM_W-1:0]           cfg_sym,
  input  logic                       cfg_len_we,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic [1:0]                 cfg_mode,
  input  logic                       arm,
  input  logic                       disarm,
  output logic                       match,
  output logic [CNT_W-1:0]           match_count,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] FULL    = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seqdet_state_t state, state_nx;
  seqdet_mode_t  mode;

  logic [SYM_W-1:0]         pat [MAX_LEN];
  logic [LEN_W-1:0]         len;
  logic [MAX_LEN*SYM_W-1:0] hist;
  logic [LEN_W-1:0]         fill, fill_nx;
  logic [SYM_W-1:0]         hist_nx [MAX_LEN];
  logic beat, arm_go, pat_ok, hit, match_evt, hist_clear;
  logic unused_oldest;

  assign beat       = (state == ST_ARMED) && in_valid;
  assign arm_go     = arm && !disarm && (state != ST_ARMED);
  assign fill_nx    = (fill == FULL) ? FULL : fill + LEN_W'(1);
  assign hit        = beat && (fill_nx >= len) && pat_ok;
  assign match_evt  = hit && !disarm;
  assign hist_clear = arm_go || (match_evt && mode == MODE_NONOVERLAP);
  // The oldest entry is shifted out by the beat being compared.
  assign unused_oldest = ^hist[MAX_LEN*SYM_W-1 -: SYM_W];

  seqdet_history #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_history (
    .clk     (clk),
    .reset_n (reset_n),
    .shift   (beat),
    .clear   (hist_clear),
    .sym     (in_sym),
    .hist    (hist),
    .fill    (fill)
  );

  // Matching is judged on the history as it will be after this beat.
  always_comb begin
    hist_nx[0] = in_sym;
    for (int i = 1; i < MAX_LEN; i++) hist_nx[i] = hist[(i-1)*SYM_W +: SYM_W];
  end

  always_comb begin
    pat_ok = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len) && hist_nx[i] != pat[IDX_W'(int'(len) - 1 - i)]) pat_ok = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    if (disarm) state_nx = ST_IDLE;
    else if (arm_go) state_nx = ST_ARMED;
    else if (match_evt && mode == MODE_ONESHOT) state_nx = ST_DONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      mode        <= MODE_OVERLAP;
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_nx;
      match <= match_evt;
      busy  <= (state_nx == ST_ARMED);
      done  <= (state_nx == ST_DONE);
      if (arm_go) begin
        mode        <= decode_mode(cfg_mode);
        match_count <= '0;
      end else if (match_evt && match_count != CNT_MAX) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) pat[i] <= '0;
      len <= FULL;
    end else if (state == ST_IDLE) begin
      if (cfg_we && int'(cfg_idx) < MAX_LEN) pat[cfg_idx] <= cfg_sym;
      if (cfg_len_we && cfg_len != '0) len <= (cfg_len > FULL) ? FULL : cfg_len;
    end
  end

endmodule

// File: tb/tb_seqdet_prog.sv
// tb/tb_seqdet_prog.sv - randomized self-checking bench for seqdet_prog against a behavioural model
module tb_seqdet_prog;

  localparam int SYM_W   = 3;
  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_sym = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [2:0] cfg_sym = '0;
  logic       cfg_len_we = 1'b0;
  logic [3:0] cfg_len = '0;
  logic [1:0] cfg_mode = '0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       match_a, busy_a, done_a, match_b, busy_b, done_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seqdet_prog #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .arm(arm), .disarm(disarm),
    .match(match_a), .match_count(cnt_a), .busy(busy_a), .done(done_a)
  );

  seqdet_prog #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .arm(arm), .disarm(disarm),
    .match(match_b), .match_count(cnt_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int failures = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int q[$];

  // Reference model: 0 idle, 1 armed, 2 done; window = symbols since last fill reset, oldest first.
  int m_st, m_mode, m_len, m_cnt;
  int m_pat[MAX_LEN];
  int m_win[$];
  bit m_match;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit model_hit();
    int base;
    if (m_win.size() < m_len) return 1'b0;
    base = m_win.size() - m_len;
    for (int j = 0; j < m_len; j++) if (m_win[base + j] != m_pat[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_mode = 0; m_len = MAX_LEN; m_cnt = 0; m_match = 1'b0;
    foreach (m_pat[i]) m_pat[i] = 0;
    m_win.delete();
  endtask

  task automatic model_step();
    bit hit;
    hit = 1'b0;
    m_match = 1'b0;
    if (m_st == 1 && in_valid) begin
      m_win.push_back(int'(in_sym));
      if (m_win.size() > MAX_LEN) void'(m_win.pop_front());
      hit = model_hit();
    end
    if (m_st == 0) begin
      if (cfg_we) m_pat[int'(cfg_idx)] = int'(cfg_sym);
      if (cfg_len_we && cfg_len != 0) m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
    end
    if (disarm) begin
      m_st = 0;
    end else if (m_st != 1 && arm) begin
      m_st = 1;
      m_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
      m_win.delete();
      m_cnt = 0;
    end else if (m_st == 1 && hit) begin
      m_match = 1'b1;
      m_cnt++;
      if (m_mode == 1) m_win.delete();
      if (m_mode == 2) m_st = 2;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("match", match_a, m_match);
    check_eq("count", cnt_a, sat(m_cnt, 255));
    check_eq("busy", busy_a, m_st == 1);
    check_eq("done", done_a, m_st == 2);
    check_eq("match_sat", match_b, m_match);
    check_eq("count_sat", cnt_b, sat(m_cnt, 3));
    pulses_a += int'(match_a);
    pulses_b += int'(match_b);
    in_valid = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0; arm = 1'b0; disarm = 1'b0;
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_match", match_a, 0);
    check_eq("rst_count", cnt_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_count_sat", cnt_b, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic write_slot(input int idx, input int sym);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_sym = 3'(sym);
    tick();
  endtask

  task automatic write_len(input int l);
    cfg_len_we = 1'b1; cfg_len = 4'(l);
    tick();
  endtask

  task automatic load_q();
    for (int i = 0; i < q.size(); i++) write_slot(i, q[i]);
    write_len(q.size());
  endtask

  task automatic do_arm(input int mode);
    arm = 1'b1; cfg_mode = 2'(mode);
    tick();
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    tick();
  endtask

  task automatic send(input int s);
    in_valid = 1'b1; in_sym = 3'(s);
    tick();
  endtask

  task automatic send_q();
    for (int i = 0; i < q.size(); i++) send(q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_match", match_a, 0);
    check_eq("reset_count", cnt_a, 0);
    check_eq("reset_busy", busy_a, 0);
    check_eq("reset_done", done_a, 0);
    reset_n = 1'b1;

    // Full-length pattern with a leading stray symbol
    q = '{1, 5, 6, 0, 6, 6, 3, 5}; load_q(); do_arm(0);
    pulses_a = 0;
    q = '{7, 1, 5, 6, 0, 6, 6, 3}; send_q();
    check_eq("t1_no_early", pulses_a, 0);
    send(5);
    check_eq("t1_pulse", match_a, 1);
    check_eq("t1_count", cnt_a, 1);

    // Overlap vs non-overlap on 6,6
    do_disarm(); q = '{6, 6}; load_q(); do_arm(0);
    repeat (4) send(6);
    check_eq("t2_overlap", cnt_a, 3);
    do_disarm(); do_arm(1);
    repeat (4) send(6);
    check_eq("t2_nonoverlap", cnt_a, 2);

    // Mismatch restart
    do_disarm(); q = '{1, 1, 2}; load_q(); do_arm(0);
    q = '{1, 1, 1, 2}; send_q();
    check_eq("t3_match", match_a, 1);
    check_eq("t3_count", cnt_a, 1);

    // One-shot with a single-symbol pattern
    do_disarm(); write_slot(0, 4); write_len(1); do_arm(2);
    send(4);
    check_eq("t4_done", done_a, 1);
    check_eq("t4_busy", busy_a, 0);
    send(4);
    check_eq("t4_count_hold", cnt_a, 1);
    do_arm(2);
    check_eq("t4_rearm_done", done_a, 0);
    check_eq("t4_rearm_busy", busy_a, 1);
    check_eq("t4_rearm_count", cnt_a, 0);

    // Config writes ignored while armed, zero length ignored, oversize clamped
    write_slot(0, 2); write_len(3);
    send(4);
    check_eq("t5_cfg_locked", match_a, 1);
    do_disarm(); write_len(0); do_arm(0);
    send(4);
    check_eq("t5_len0_ignored", match_a, 1);
    do_disarm(); q = '{1, 2, 3, 4, 5, 6, 7, 0}; load_q(); write_len(12); do_arm(0);
    pulses_a = 0;
    q = '{2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0}; send_q();
    check_eq("t5_clamp_pulses", pulses_a, 1);

    // Saturation, disarm on a completing beat, async reset mid-run
    do_disarm(); write_slot(0, 4); write_len(1); do_arm(0);
    pulses_b = 0;
    repeat (5) send(4);
    check_eq("t6_sat_count", cnt_b, 3);
    check_eq("t6_sat_pulses", pulses_b, 5);
    check_eq("t6_wide_count", cnt_a, 5);
    in_valid = 1'b1; in_sym = 3'd4; disarm = 1'b1; tick();
    check_eq("t6_disarm_nopulse", match_a, 0);
    check_eq("t6_disarm_count", cnt_a, 5);
    do_arm(0); send(4);
    async_reset();
    do_arm(0);
    pulses_a = 0;
    repeat (7) send(0);
    check_eq("t6_len_default_wait", pulses_a, 0);
    send(0);
    check_eq("t6_len_default_match", match_a, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_sym     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_idx    = 3'($urandom_range(0, 7));
      cfg_sym    = 3'($urandom_range(0, 1));
      cfg_len_we = ($urandom_range(0, 19) == 0);
      cfg_len    = 4'($urandom_range(0, 15));
      cfg_mode   = 2'($urandom_range(0, 3));
      arm        = ($urandom_range(0, 29) == 0);
      disarm     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 999) == 0) async_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
